// File: rtl/des_block_sequencer.sv
// Byte-to-block sequencer around a DES engine: packs RX bytes into one block,
// starts the engine, guards it with a watchdog and unpacks the result to TX.
module des_block_sequencer #(
    parameter int BLOCK_BYTES = 8,
    parameter int DES_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       rx_pop,
    input  logic                       flush,
    input  logic                       encrypt,
    output logic                       des_start,
    output logic [BLOCK_BYTES*8-1:0]   des_block_in,
    output logic                       des_reverse,
    input  logic                       des_done,
    input  logic [BLOCK_BYTES*8-1:0]   des_block_out,
    input  logic                       tx_full,
    output logic                       tx_push,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic                       des_error,
    output logic [15:0]                block_count
);
    localparam int BW  = BLOCK_BYTES * 8;
    localparam int LW  = $clog2(BW);
    localparam int WDW = $clog2(DES_TIMEOUT);
    localparam logic [3:0]     LAST_IDX = 4'(BLOCK_BYTES - 1);
    localparam logic [3:0]     FULL_CNT = 4'(BLOCK_BYTES);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(DES_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t          state_q;
    logic [3:0]      byte_cnt_q;
    logic [3:0]      out_cnt_q;
    logic [WDW-1:0]  wdog_q;
    logic [BW-1:0]   block_q;
    logic [BW-1:0]   out_q;
    logic            rev_q;
    logic            start_q;
    logic            err_q;
    logic [15:0]     blk_cnt_q;
    logic            fill_s;
    logic [LW-1:0]   lane_lo_s;

    assign fill_s    = (state_q == ST_IDLE) || (state_q == ST_FILL);
    assign rx_pop    = rx_valid && fill_s && (byte_cnt_q < FULL_CNT);
    // Lane for byte k sits at bits [BW-1-8k -: 8]; only meaningful in FILL.
    assign lane_lo_s = LW'((BLOCK_BYTES - 1 - int'(byte_cnt_q)) * 8);

    assign tx_push      = (state_q == ST_DRAIN) && !tx_full;
    assign tx_data      = out_q[BW-1 -: 8];
    assign des_start    = start_q;
    assign des_block_in = block_q;
    assign des_reverse  = rev_q;
    assign busy         = (state_q != ST_IDLE);
    assign des_error    = err_q;
    assign block_count  = blk_cnt_q;

    // Sequencer FSM with all datapath registers and pulse outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 4'd0;
            out_cnt_q  <= 4'd0;
            wdog_q     <= '0;
            block_q    <= '0;
            out_q      <= '0;
            rev_q      <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            blk_cnt_q  <= 16'd0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_pop) begin
                        // Unfilled lanes start at zero, so a flush needs no extra padding step.
                        block_q    <= {rx_data, {(BW-8){1'b0}}};
                        byte_cnt_q <= 4'd1;
                        rev_q      <= !encrypt;
                        if (flush) begin
                            start_q <= 1'b1;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (rx_pop) begin
                        block_q[lane_lo_s +: 8] <= rx_data;
                        byte_cnt_q              <= byte_cnt_q + 4'd1;
                        if ((byte_cnt_q == LAST_IDX) || flush) begin
                            start_q <= 1'b1;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end else if (flush) begin
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end
                ST_START: begin
                    wdog_q  <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (des_done) begin
                        out_q     <= des_block_out;
                        out_cnt_q <= 4'd0;
                        wdog_q    <= '0;
                        state_q   <= ST_DRAIN;
                    end else if (wdog_q == WD_LIMIT) begin
                        err_q      <= 1'b1;
                        block_q    <= '0;
                        out_q      <= '0;
                        rev_q      <= 1'b0;
                        byte_cnt_q <= 4'd0;
                        out_cnt_q  <= 4'd0;
                        wdog_q     <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        wdog_q  <= wdog_q + 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (!tx_full) begin
                        out_q     <= {out_q[BW-9:0], 8'h00};
                        out_cnt_q <= out_cnt_q + 4'd1;
                        if (out_cnt_q == LAST_IDX) begin
                            byte_cnt_q <= 4'd0;
                            blk_cnt_q  <= blk_cnt_q + 16'd1;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/des_block_sequencer.md
Name: des_block_sequencer

Overview:
Sits between the USB receive FIFO, the DES round datapath/controller and the USB transmit FIFO. Packs 8 received bytes into a 64-bit block and starts one DES operation. Waits for the engine's completion pulse, then unpacks the result into the TX FIFO byte by byte. Also owns mode latching, zero-padding of short trailing blocks, a completion watchdog and a block counter.

Parameters:
BLOCK_BYTES, 8, bytes per DES block (the design supports only 8; block width is BLOCK_BYTES*8)
DES_TIMEOUT, 64, cycles allowed in WAIT_DES before abort

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset, synchronous, active-low
rx_valid  input  1  RX FIFO has a byte (not empty)
rx_data  input  8  RX FIFO head byte
rx_pop  output  1  pop RX FIFO this cycle
flush  input  1  end-of-packet; close the partial block
encrypt  input  1  1=encrypt, 0=decrypt; sampled on the first byte of a block
des_start  output  1  one-cycle start pulse to DES engine
des_block_in  output  64  plaintext/ciphertext block to engine
des_reverse  output  1  key-order reverse (=!latched encrypt)
des_done  input  1  one-cycle completion pulse from engine
des_block_out  input  64  engine result, valid when des_done=1
tx_full  input  1  TX FIFO full
tx_push  output  1  write tx_data to TX FIFO this cycle
tx_data  output  8  output byte
busy  output  1  state != IDLE
des_error  output  1  one-cycle pulse on watchdog abort
block_count  output  16  completed blocks since reset, wraps

Behaviour:
- Reset (n_rst=0 at a rising edge): state=IDLE, byte_cnt=0, all data/out registers=0, block_count=0, watchdog=0. Every output is 0 during and after reset until stimulus.
- rx_pop = rx_valid AND state in {IDLE, FILL} AND byte_cnt<8. This is combinational; a byte is consumed on the same edge.
- IDLE:
  - rx_pop → load byte into bits [63:56], byte_cnt=1, latch mode=encrypt, go to FILL.
  - flush with no byte is ignored; stay in IDLE.
- FILL:
  - Each pop loads the byte into the next lower lane (byte k → bits [63-8k:56-8k]).
  - When the 8th byte is popped → START.
  - flush with byte_cnt>0 → START, remaining lanes forced to 0x00.
  - flush coincident with a pop: the byte is taken first, then padding applies.
  - flush is ignored in all other states.
- START: des_start=1 for exactly one cycle → WAIT_DES. des_block_in and des_reverse hold stable from START until leaving WAIT_DES.
- WAIT_DES:
  - Watchdog increments each cycle.
  - des_done=1 → capture des_block_out into out_reg, clear watchdog → DRAIN.
  - Watchdog reaches DES_TIMEOUT-1 without des_done → des_error pulse for one cycle, discard the block, clear all registers, go to IDLE; block_count unchanged.
  - des_done outside WAIT_DES is ignored.
- DRAIN:
  - When !tx_full: tx_push=1, tx_data=out_reg[63:56], shift out_reg left 8, out_cnt++.
  - When tx_full=1: tx_push=0 and state holds.
  - After the 8th push → IDLE, block_count++ (0xFFFF→0x0000).
  - Padded blocks always drain all 8 bytes.
- Throughput bound: 8 fill + 1 start + DES latency + 8 drain cycles per block. No overlap of fill and drain.
- Synchronous reset asserted mid-operation aborts immediately with no des_error and no push.

Test Plan:
- Reset, then 8 consecutive bytes 0x01..0x08 with encrypt=1 → des_block_in=0x0102030405060708, des_start pulses once on the cycle after the 8th pop, des_reverse=0.
- Engine returns des_done with 0xA1B2C3D4E5F60718 after 20 cycles, tx_full=0 → tx_data sequence A1,B2,C3,D4,E5,F6,07,18 on 8 consecutive cycles; block_count=1; busy falls.
- 3 bytes 0xAA,0xBB,0xCC, then flush coincident with the 3rd byte, encrypt=0 → des_block_in=0xAABBCC0000000000, des_reverse=1; flush alone in IDLE → no des_start.
- During DRAIN hold tx_full=1 for 5 cycles after the 2nd byte → no tx_push while full; remaining 6 bytes resume in order, none lost or duplicated.
- Never assert des_done → des_error pulses exactly DES_TIMEOUT cycles after entering WAIT_DES; state IDLE; block_count unchanged; next block processes normally.
- Assert n_rst=0 for one edge in WAIT_DES → all outputs 0 next cycle; a late des_done produces no TX pushes.
